// File: rtl/fifo_read_arbiter_pkg.sv
// Shared definitions for the FIFO read-side scheduler: FSM encoding and the
// round-robin search used by the channel picker.
package fifo_read_arbiter_pkg;

    // Widest channel count the round-robin helper supports.
    localparam int MAX_CH = 8;
    localparam int RR_W   = 3;

    // State encoding of the read scheduler.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ISSUE   = ST_ISSUE,
        CAPTURE = ST_CAPTURE,
        HOLD    = ST_HOLD
    } state_t;

    // First set bit of req searching last+1, last+2, ... with wrap at top
    // (top = channel count - 1). The wrap is an explicit compare so that
    // non-power-of-2 channel counts work. Returns last when req is empty;
    // callers qualify the result with |req.
    function automatic logic [RR_W-1:0] next_rr(
        input logic [RR_W-1:0]   last,
        input logic [MAX_CH-1:0] req,
        input logic [RR_W-1:0]   top
    );
        logic [RR_W-1:0] idx;
        logic            hit;
        idx     = last;
        hit     = 1'b0;
        next_rr = last;
        for (int k = 0; k < MAX_CH; k++) begin
            if (k <= int'(top)) begin
                idx = (idx == top) ? '0 : idx + 1'b1;
                if (req[idx] && !hit) begin
                    next_rr = idx;
                    hit     = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_pick.sv
// Combinational round-robin priority selector: finds the first requesting
// channel after last_grant. Shared with the write-side scheduler.
module fifo_read_arbiter_rr_pick
    import fifo_read_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic              found,
    output logic [CH_W-1:0]   idx
);

    logic [MAX_CH-1:0] req_ext;
    logic [RR_W-1:0]   last_ext;
    logic [RR_W-1:0]   pick;

    // Widen to the helper's fixed width and run the rotated search.
    always_comb begin
        req_ext  = MAX_CH'(req);
        last_ext = RR_W'(last_grant);
        pick     = next_rr(last_ext, req_ext, RR_W'(NUM_CH - 1));
        found    = |req;
        idx      = CH_W'(pick);
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin read scheduler: shares one valid/ready consumer between
// NUM_CH FIFO read ports, issuing single-cycle read enables, capturing the
// FIFO's registered data one cycle later and bounding each grant to
// BURST_MAX words.
module fifo_read_arbiter
    import fifo_read_arbiter_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CH_W       = 2,
    parameter int BURST_MAX  = 4
) (
    input  logic                         clk_read,
    input  logic                         a_Reset,
    input  logic                         arb_en,
    input  logic [NUM_CH-1:0]            ch_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_rd_en,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    state_t                  state, state_d;
    logic [CH_W-1:0]         grant, grant_d;
    logic [CH_W-1:0]         last_grant, last_grant_d;
    logic [3:0]              burst_cnt, burst_cnt_d;
    logic [DATA_WIDTH-1:0]   out_data_d;
    logic [CH_W-1:0]         out_ch_d;
    logic                    out_valid_d;
    logic [NUM_CH-1:0]       rd_en_q, rd_en_d;
    logic                    busy_d;

    logic                    pick_found;
    logic [CH_W-1:0]         pick_idx;

    fifo_read_arbiter_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .req        (~ch_empty),
        .last_grant (last_grant),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // The enable is a registered one-hot pulse for the ISSUE cycle, masked by
    // the live empty flag so an underflow read can never leave the block.
    assign ch_rd_en = rd_en_q & ~ch_empty;

    // Next-state and next-output decode for the four-state read sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d      = state;
        grant_d      = grant;
        last_grant_d = last_grant;
        burst_cnt_d  = burst_cnt;
        out_data_d   = out_data;
        out_ch_d     = out_ch;
        out_valid_d  = out_valid;
        rd_en_d      = '0;

        case (state)
            IDLE: begin
                if (arb_en && pick_found) begin
                    grant_d           = pick_idx;
                    burst_cnt_d       = '0;
                    rd_en_d[pick_idx] = 1'b1;
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                // Defensive: the FIFO drained under us, give the grant up.
                if (ch_empty[grant]) begin
                    last_grant_d = grant;
                    state_d      = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                out_data_d  = ch_data[grant*DATA_WIDTH +: DATA_WIDTH];
                out_ch_d    = grant;
                out_valid_d = 1'b1;
                burst_cnt_d = burst_cnt + 4'd1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (arb_en && (burst_cnt < 4'(BURST_MAX)) && !ch_empty[grant]) begin
                        rd_en_d[grant] = 1'b1;
                        state_d        = ISSUE;
                    end else begin
                        last_grant_d = grant;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset drops any held word immediately.
    always_ff @(posedge clk_read or posedge a_Reset) begin
        if (a_Reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            burst_cnt  <= '0;
            out_data   <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            rd_en_q    <= '0;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state      <= state_d;
            grant      <= grant_d;
            last_grant <= last_grant_d;
            burst_cnt  <= burst_cnt_d;
            out_data   <= out_data_d;
            out_ch     <= out_ch_d;
            out_valid  <= out_valid_d;
            rd_en_q    <= rd_en_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Scoreboard bench for fifo_read_arbiter: FIFO models feed the DUT, a
// queue-based rotation model predicts the word order, and a monitor checks
// each handshake plus enable/latency/stability rules.
module tb_fifo_read_arbiter;

    localparam int NUM_CH     = 4;
    localparam int DW         = 8;
    localparam int CH_W       = 2;
    localparam int BURST_MAX  = 4;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [DW-1:0]   data;
    } exp_t;

    logic                   clk_read = 1'b0;
    logic                   a_Reset;
    logic                   arb_en;
    logic [NUM_CH-1:0]      ch_empty;
    logic [NUM_CH*DW-1:0]   ch_data;
    logic [NUM_CH-1:0]      ch_rd_en;
    logic [DW-1:0]          out_data;
    logic [CH_W-1:0]        out_ch;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    fifo_read_arbiter #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .CH_W       (CH_W),
        .BURST_MAX  (BURST_MAX)
    ) dut (
        .clk_read  (clk_read),
        .a_Reset   (a_Reset),
        .arb_en    (arb_en),
        .ch_empty  (ch_empty),
        .ch_data   (ch_data),
        .ch_rd_en  (ch_rd_en),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk_read = ~clk_read;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] fifo_q [NUM_CH][$];
    logic [DW-1:0] mdl_q  [NUM_CH][$];
    exp_t          exp_q[$];
    int            model_last = NUM_CH - 1;
    int            ready_mode = 0;      // 0 low, 1 high, 2 random
    logic [NUM_CH-1:0] rd_sample = '0;
    int            cyc = 0;
    int            last_issue = 0;
    int            rd_pulses [NUM_CH];
    int            hs_count = 0;
    int            hs_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_read);
            #2;
        end
    endtask

    // Word goes into both the FIFO model and the reference model.
    task automatic load(input int ch, input logic [DW-1:0] d);
        fifo_q[ch].push_back(d);
        mdl_q[ch].push_back(d);
    endtask

    // Reference: visit non-empty channels in rotation after the last one
    // served, taking up to BURST_MAX words from each visit.
    task automatic run_model();
        int c;
        int any;
        forever begin
            any = 0;
            for (int i = 0; i < NUM_CH; i++) if (mdl_q[i].size() != 0) any = 1;
            if (any == 0) break;
            c = model_last;
            do c = (c + 1) % NUM_CH; while (mdl_q[c].size() == 0);
            for (int k = 0; k < BURST_MAX && mdl_q[c].size() != 0; k++)
                exp_q.push_back('{ch: CH_W'(c), data: mdl_q[c].pop_front()});
            model_last = c;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            tick();
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (out_valid) break;
            tick();
        end
        check({name, "_valid_seen"}, out_valid, 1);
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < NUM_CH; i++) rd_pulses[i] = 0;
    endtask

    // FIFO models: registered data_out, pop on the sampled enable.
    initial begin
        ch_empty = '1;
        ch_data  = '0;
        forever begin
            @(posedge clk_read);
            #1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (rd_sample[i] && fifo_q[i].size() != 0)
                    ch_data[i*DW +: DW] = fifo_q[i].pop_front();
                ch_empty[i] = (fifo_q[i].size() == 0);
            end
        end
    end

    // Consumer ready driver.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk_read);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples on the falling edge.
    initial begin
        logic          prev_valid;
        logic          prev_ready;
        logic [DW-1:0] prev_data;
        logic [CH_W-1:0] prev_ch;
        exp_t          e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data  = '0;
        prev_ch    = '0;
        forever begin
            @(negedge clk_read);
            cyc++;
            rd_sample = ch_rd_en;
            if (ch_rd_en != '0) begin
                check("rd_en_onehot", 32'($onehot(ch_rd_en)), 1);
                check("rd_en_while_empty", 32'(ch_rd_en & ch_empty), 0);
                last_issue = cyc;
                for (int i = 0; i < NUM_CH; i++) if (ch_rd_en[i]) rd_pulses[i]++;
            end
            if (out_valid && !prev_valid)
                check("enable_to_valid_latency", cyc - last_issue, 2);
            if (out_valid && prev_valid && !prev_ready) begin
                check("hold_data_stable", out_data, prev_data);
                check("hold_ch_stable", out_ch, prev_ch);
            end
            if (out_valid && out_ready) begin
                hs_count++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_word: got ch%0d data 0x%0h, expected no word", out_ch, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word_ch", out_ch, e.ch);
                    check("word_data", out_data, e.data);
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_ch    = out_ch;
        end
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        a_Reset = 1'b1;
        arb_en  = 1'b0;
        clear_pulses();
        tick(3);

        // Reset state.
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_en", ch_rd_en, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        a_Reset = 1'b0;
        arb_en  = 1'b1;
        tick(2);

        // Single-channel burst: 4 words, regrant, 2 words; ready always high.
        ready_mode = 1;
        tick(2);
        hs_cyc.delete();
        for (int i = 0; i < 6; i++) load(1, DW'(8'h10 + i));
        run_model();
        wait_drain("burst", 200);
        check("burst_handshakes", hs_cyc.size(), 6);
        if (hs_cyc.size() == 6) begin
            check("burst_gap1", hs_cyc[1] - hs_cyc[0], 3);
            check("burst_gap2", hs_cyc[2] - hs_cyc[1], 3);
            check("burst_gap3", hs_cyc[3] - hs_cyc[2], 3);
            check("regrant_gap", hs_cyc[4] - hs_cyc[3], 4);
            check("burst_gap5", hs_cyc[5] - hs_cyc[4], 3);
        end

        // Fairness: two words per channel, random backpressure.
        ready_mode = 2;
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < 2; k++) load(c, DW'(8'h40 + 16 * c + k));
        run_model();
        wait_drain("fair", 400);

        // Backpressure in HOLD.
        ready_mode = 0;
        tick(2);
        load(0, 8'h3C);
        run_model();
        wait_valid("bp", 20);
        clear_pulses();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_data", out_data, 8'h3C);
        end
        check("bp_no_rd_en", rd_pulses[0] + rd_pulses[1] + rd_pulses[2] + rd_pulses[3], 0);
        n = hs_count;
        ready_mode = 1;
        tick();
        ready_mode = 0;
        tick(6);
        check("bp_one_handshake", hs_count - n, 1);
        check("bp_valid_after", out_valid, 0);
        wait_drain("bp", 50);

        // Empty boundary: one word, burst must stop after it.
        ready_mode = 2;
        clear_pulses();
        load(3, 8'h77);
        run_model();
        wait_drain("empty", 100);
        check("empty_one_pulse", rd_pulses[3], 1);
        check("empty_idle", busy, 0);

        // Reset mid-HOLD with ch2 word 0xA5 held.
        ready_mode = 0;
        tick(2);
        fifo_q[2].push_back(8'hA5);   // dropped by reset: not modelled
        wait_valid("rst_hold", 20);
        check("rst_hold_data", out_data, 8'hA5);
        check("rst_hold_ch", out_ch, 2);
        check("rst_hold_busy", busy, 1);
        #1;
        a_Reset = 1'b1;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_rd_en", ch_rd_en, 0);
        check("rst_async_busy", busy, 0);
        tick();
        a_Reset    = 1'b0;
        model_last = NUM_CH - 1;
        ready_mode = 2;
        load(3, 8'hB3);
        load(0, 8'hB0);
        run_model();
        wait_drain("post_rst", 100);

        // arb_en drop in CAPTURE of word 2 of 4 on ch0; ch1 waiting.
        ready_mode = 1;
        clear_pulses();
        n = hs_count;
        for (int k = 0; k < 4; k++) fifo_q[0].push_back(DW'(8'hC0 + k));
        for (int k = 0; k < 2; k++) fifo_q[1].push_back(DW'(8'hD0 + k));
        for (int k = 0; k < 2; k++) exp_q.push_back('{ch: CH_W'(0), data: DW'(8'hC0 + k)});
        for (int k = 0; k < 2; k++) exp_q.push_back('{ch: CH_W'(1), data: DW'(8'hD0 + k)});
        for (int k = 2; k < 4; k++) exp_q.push_back('{ch: CH_W'(0), data: DW'(8'hC0 + k)});
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rd_pulses[0] >= 2) break;
        end
        arb_en = 1'b0;
        tick(20);
        check("en_drop_words", hs_count - n, 2);
        check("en_drop_ch0_pulses", rd_pulses[0], 2);
        check("en_drop_ch1_pulses", rd_pulses[1], 0);
        check("en_drop_idle", busy, 0);
        arb_en = 1'b1;
        model_last = 0;
        wait_drain("en_resume", 200);

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            ready_mode = 2;
            for (int c = 0; c < NUM_CH; c++) begin
                n = $urandom_range(0, 6);
                for (int k = 0; k < n; k++) load(c, DW'($urandom));
            end
            run_model();
            wait_drain("random", 3000);
            tick(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_read_arbiter.md
Name: fifo_read_arbiter

Overview:
- Round-robin read scheduler that shares one downstream consumer between NUM_CH independent FIFO read ports, all in the clk_read domain.
- Issues single-cycle read enables to the selected FIFO and captures its registered data_out one cycle later.
- Presents each word on a valid/ready output interface, tagged with its source channel.
- Bounds each grant to BURST_MAX words so no channel can starve the others.

Parameters:
- NUM_CH, 4, number of FIFO read ports arbitrated (2..8)
- DATA_WIDTH, 8, word width of each FIFO and of the output
- CH_W, 2, channel index width, equal to clog2(NUM_CH)
- BURST_MAX, 4, maximum words taken from one channel per grant (1..15)

Ports:
- clk_read  in  1  read-side clock shared with all FIFO read ports
- a_Reset  in  1  reset, asynchronous, active-high
- arb_en  in  1  allows new grants when high
- ch_empty  in  NUM_CH  per-channel FIFO empty flag; bit i = channel i
- ch_data  in  NUM_CH*DATA_WIDTH  per-channel FIFO data_out; channel i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- ch_rd_en  out  NUM_CH  per-channel read enable, one-hot or zero
- out_data  out  DATA_WIDTH  captured word
- out_ch  out  CH_W  source channel of out_data
- out_valid  out  1  out_data/out_ch valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert; release sampled on clk_read):
  - state=IDLE; ch_rd_en=0, out_data=0, out_ch=0, out_valid=0, busy=0.
  - last_grant=NUM_CH-1, so the first search starts at channel 0.
  - burst_cnt=0.
- Reset mid-operation: all of the above applies immediately. Any word in HOLD is dropped. A read enable already issued is not replayed.
- State machine, 4 states, all outputs registered:
- IDLE:
  - If arb_en=1 and any ch_empty bit is 0, select the first non-empty channel searching last_grant+1, last_grant+2, ... modulo NUM_CH.
  - Latch the selection as grant; burst_cnt=0; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - ch_rd_en[grant]=1 for exactly this cycle, provided ch_empty[grant]=0 this cycle; go to CAPTURE.
  - If ch_empty[grant]=1 (defensive case), assert no enable; set last_grant=grant; go to IDLE.
- CAPTURE:
  - ch_rd_en=0.
  - out_data <= ch_data[grant], out_ch <= grant, out_valid <= 1; burst_cnt <= burst_cnt+1; go to HOLD.
  - Read latency is fixed: enable cycle N, data captured at end of cycle N+1, out_valid visible from cycle N+2.
- HOLD:
  - out_valid, out_data and out_ch stay stable until out_ready=1.
  - On the handshake: out_valid <= 0. Then:
    - If arb_en=1, burst_cnt<BURST_MAX and ch_empty[grant]=0, go to ISSUE on the same grant.
    - Otherwise set last_grant=grant and go to IDLE.
- Peak throughput: one word per 3 cycles within a burst and one word per 4 cycles across a regrant. This is acceptable for the target rates.
- arb_en deassert:
  - Never aborts a word in flight; the word completes through HOLD.
  - After the handshake the arbiter returns to IDLE and makes no further grants while arb_en=0.
- Empty flags are sampled only in IDLE, ISSUE and the HOLD exit decision. An underflow read is never generated.
- Widths and counters:
  - burst_cnt is 4 bits and saturates logically via the BURST_MAX compare.
  - Channel index wrap uses an explicit compare against NUM_CH-1, so non-power-of-2 NUM_CH is legal.
- Simultaneous events: when several channels become non-empty in the same cycle, the rotation order decides. Strict fairness: a channel waits at most (NUM_CH-1) bursts.

Decomposition:
- Shared package: state encoding localparams (IDLE, ISSUE, CAPTURE, HOLD), and a function next_rr(last, req) returning the rotated first-set index.
- One sub-module, rr_pick: combinational round-robin priority selector. Inputs are the req vector and last_grant; outputs are the found flag and the index. It is reusable by the write-side scheduler.

Test Plan:
- Reset defaults: assert a_Reset mid-HOLD holding ch2 data 0xA5 -> out_valid drops immediately, ch_rd_en=0, and the first grant after release goes to ch0.
- Single-channel burst: ch1 holds 6 words 0x10..0x15, BURST_MAX=4, out_ready=1 -> out_data 0x10..0x13 with out_ch=1, then IDLE, then 0x14,0x15. Enable-to-valid latency is 2 cycles.
- Round-robin fairness: ch0..ch3 each hold 2 words, BURST_MAX=1 -> out_ch sequence 0,1,2,3,0,1,2,3.
- Backpressure: out_ready=0 for 10 cycles during HOLD with 0x3C -> out_data stays 0x3C, no ch_rd_en pulses; on ready exactly one handshake.
- Empty boundary: ch3 holds 1 word, BURST_MAX=4 -> exactly one ch_rd_en[3] pulse, return to IDLE, and ch_rd_en never asserts while ch_empty=1.
- arb_en drop mid-burst: clear arb_en in CAPTURE of word 2 of 4 -> word 2 delivered, then IDLE; no further grants until arb_en=1, after which the next channel in rotation is granted.
